mcp_result_serializer: RTL and testbench

- Downstream stage of the 64-bit multi-cycle ripple-carry adder.
- Waits a fixed number of clocks for the adder's combinational sum to settle after a request, then captures the full-width sum into a shift register.
- Streams the captured sum out LSB-first over a valid/ready bit-serial interface.
- Replaces the per-cycle result register, so the adder path is a genuine multi-cycle path under a matching SDC multicycle constraint.

---
 rtl/mcp_pkg.sv | 14 +
 rtl/settle_timer.sv | 38 +++
 rtl/mcp_result_serializer.sv | 105 ++++++++++
 tb/tb_mcp_result_serializer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcp_pkg.sv
// Shared definitions for the multi-cycle adder and its result serializer.
package mcp_pkg;

    // Defaults shared with the adder top and the SDC generation script.
    localparam int unsigned BITS          = 64;
    localparam int unsigned SETTLE_CYCLES = 4;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StShift
    } mcp_state_e;

endpackage

// File: rtl/settle_timer.sv
// Down-counter that measures the settle window of the multi-cycle adder path.
// expired_o is high once the counter has reached zero; load_i restarts the window.
module settle_timer #(
    parameter int unsigned SETTLE_CYCLES = mcp_pkg::SETTLE_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned TW = $clog2(SETTLE_CYCLES + 1);

    logic [TW-1:0] cnt_q, cnt_d;

    // Load takes priority over decrement; the counter parks at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = TW'(SETTLE_CYCLES - 1);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/mcp_result_serializer.sv
// Captures the settled multi-cycle adder sum and streams it out LSB-first over
// a valid/ready bit-serial interface. sum_in_i is only sampled on the capture
// edge, which makes the adder a true multi-cycle path.
module mcp_result_serializer #(
    parameter int unsigned BITS          = mcp_pkg::BITS,
    parameter int unsigned SETTLE_CYCLES = mcp_pkg::SETTLE_CYCLES
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            operand_changed_i,
    input  logic [BITS-1:0] sum_in_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic            out_bit_o,
    output logic            out_last_o,
    output logic            busy_o,
    output logic            done_o
);

    import mcp_pkg::*;

    localparam int unsigned CNT_W = $clog2(BITS);

    mcp_state_e        state_q, state_d;
    logic [BITS-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic              done_q, done_d;
    logic              tmr_load, tmr_en, tmr_expired;
    logic              last;

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (tmr_load),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    assign last = (state_q == StShift) && (idx_q == CNT_W'(BITS - 1));

    // Next-state logic: settle window with restart, capture, then handshake-driven shifting.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                // operand_changed_i is irrelevant here; the window is always loaded in full.
                if (start_i) begin
                    tmr_load = 1'b1;
                    state_d  = StSettle;
                end
            end
            StSettle: begin
                tmr_en = 1'b1;
                if (operand_changed_i) begin
                    tmr_load = 1'b1;
                end else if (tmr_expired) begin
                    shift_d = sum_in_i;
                    idx_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (out_ready_i) begin
                    shift_d = {1'b0, shift_q[BITS-1:1]};
                    idx_d   = idx_q + CNT_W'(1);
                    if (last) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, data and done-pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            shift_q <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign out_valid_o = (state_q == StShift);
    assign out_bit_o   = shift_q[0];
    assign out_last_o  = last;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;

endmodule

// File: tb/tb_mcp_result_serializer.sv
// Self-checking bench for mcp_result_serializer: table-driven transfers,
// randomized transfers against a reference model, and an async reset sequence.
module tb_mcp_result_serializer;

    localparam int unsigned BITS = 64;
    localparam int unsigned S    = 4;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic            opc;
    logic [BITS-1:0] sum_in;
    logic            out_valid;
    logic            out_ready;
    logic            out_bit;
    logic            out_last;
    logic            busy;
    logic            done;

    int n_checks = 0;
    int n_fail   = 0;

    mcp_result_serializer #(
        .BITS          (BITS),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .start_i           (start),
        .operand_changed_i (opc),
        .sum_in_i          (sum_in),
        .out_valid_o       (out_valid),
        .out_ready_i       (out_ready),
        .out_bit_o         (out_bit),
        .out_last_o        (out_last),
        .busy_o            (busy),
        .done_o            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transfer: sum_a driven at start, sum_b from edge chg onward (chg<1: never),
    // ready mode 0=always, 1=pattern 1,0,0, 2=random; flags adds ignored requests.
    typedef struct {
        logic [63:0] sum_a;
        int          chg;
        logic [63:0] sum_b;
        int          mode;
        bit          flags;
        logic [63:0] exp_val;
        int          first;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the window is S edges after the last operand change seen while
    // waiting; the value streamed is whatever sum_in held at that edge.
    function automatic void model(input logic [63:0] a, input logic [63:0] b, input int chg,
                                  output logic [63:0] val, output int first);
        int cap;
        cap = S;
        if (chg >= 1 && chg <= cap) cap = chg + S;
        first = cap;
        val   = (chg >= 1 && chg <= cap) ? b : a;
    endfunction

    task automatic run_vec(input int id, input vec_t v);
        int          n;
        int          got;
        int          k;
        int          dones;
        int          e;
        bit          fin;
        bit          exp_done;
        bit          prev_hold;
        logic        prev_bit;
        logic [63:0] recv;
        string       nm;
        nm        = $sformatf("vec%0d", id);
        got       = 0;
        k         = 0;
        dones     = 0;
        fin       = 1'b0;
        exp_done  = 1'b0;
        prev_hold = 1'b0;
        prev_bit  = 1'b0;
        recv      = '0;
        sum_in    = v.sum_a;
        start     = 1'b1;
        opc       = 1'b0;
        out_ready = 1'b0;
        step();
        start = 1'b0;
        chk({nm, " busy after start"}, 64'(busy), 64'd1);
        chk({nm, " done low after start"}, 64'(done), 64'd0);
        n = 0;
        while (!fin && n < 2000) begin
            chk({nm, " done"}, 64'(done), 64'(exp_done));
            if (done) dones++;
            if (exp_done) begin
                chk({nm, " busy low at done"}, 64'(busy), 64'd0);
                chk({nm, " valid low at done"}, 64'(out_valid), 64'd0);
                fin = 1'b1;
            end else begin
                chk($sformatf("%s valid n=%0d", nm, n), 64'(out_valid),
                    64'(n >= v.first && got < 64));
                if (out_valid) begin
                    chk($sformatf("%s bit%0d", nm, got), 64'(out_bit), 64'(v.exp_val[got]));
                    chk($sformatf("%s last%0d", nm, got), 64'(out_last), 64'(got == 63));
                    if (prev_hold) chk({nm, " hold stable"}, 64'(out_bit), 64'(prev_bit));
                end
                e = n + 1;
                sum_in = (v.chg >= 1 && e >= v.chg) ? v.sum_b : v.sum_a;
                opc    = (e == v.chg);
                start  = 1'b0;
                if (v.flags) begin
                    start = (e == 2) || (e == v.first + 3);
                    if (e > v.first) begin
                        sum_in = ~v.sum_a;
                        opc    = e[0];
                    end
                end
                case (v.mode)
                    0:       out_ready = 1'b1;
                    1:       out_ready = (k % 3 == 0);
                    default: out_ready = 1'($urandom_range(0, 1));
                endcase
                prev_hold = out_valid && !out_ready;
                prev_bit  = out_bit;
                if (out_valid) begin
                    k++;
                    if (out_ready) begin
                        recv[got] = out_bit;
                        got++;
                        if (got == 64) exp_done = 1'b1;
                    end
                end
                step();
                n++;
            end
        end
        start     = 1'b0;
        opc       = 1'b0;
        out_ready = 1'b0;
        if (!fin) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: got %0d bits, expected 64", nm, got);
        end
        chk({nm, " value"}, recv, v.exp_val);
        chk({nm, " done count"}, 64'(dones), 64'd1);
    endtask

    vec_t tbl[6];
    vec_t rv;
    int   agot;
    int   guard;

    initial begin
        rst_n     = 1'b1;
        start     = 1'b0;
        opc       = 1'b0;
        sum_in    = '0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_bit", 64'(out_bit), 64'd0);
        chk("rst out_last", 64'(out_last), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle out_valid", 64'(out_valid), 64'd0);
        end

        // Hand-derived expectations (first = cycles from start edge to first valid).
        tbl[0] = '{64'h0123_4567_89AB_CDEF, -1, 64'h0, 0, 1'b0, 64'h0123_4567_89AB_CDEF, 4};
        tbl[1] = '{64'h5555_5555_5555_5555, 2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0,
                   64'hFFFF_FFFF_FFFF_FFFF, 6};
        tbl[2] = '{64'h8000_0000_0000_0001, -1, 64'h0, 1, 1'b0, 64'h8000_0000_0000_0001, 4};
        tbl[3] = '{64'hDEAD_BEEF_CAFE_F00D, -1, 64'h0, 0, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 4};
        tbl[4] = '{64'h0000_0000_0000_0001, 4, 64'hAAAA_AAAA_AAAA_AAAA, 0, 1'b0,
                   64'hAAAA_AAAA_AAAA_AAAA, 8};
        tbl[5] = '{64'h1357_9BDF_2468_ACE0, 5, 64'h0, 0, 1'b0, 64'h1357_9BDF_2468_ACE0, 4};
        for (int i = 0; i < 6; i++) run_vec(i, tbl[i]);

        for (int i = 0; i < 6; i++) begin
            rv.sum_a = {$urandom, $urandom};
            rv.sum_b = {$urandom, $urandom};
            rv.chg   = int'($urandom_range(0, 7));
            if (rv.chg == 0) rv.chg = -1;
            rv.mode  = 2;
            rv.flags = 1'b0;
            model(rv.sum_a, rv.sum_b, rv.chg, rv.exp_val, rv.first);
            run_vec(10 + i, rv);
        end

        // Async reset after bit 20 has been accepted.
        sum_in    = 64'hF0F0_F0F0_F0F0_F0F1;
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        agot  = 0;
        guard = 0;
        while (agot < 21 && guard < 200) begin
            if (out_valid) agot++;
            step();
            guard++;
        end
        chk("arst bits accepted", 64'(agot), 64'd21);
        #2 rst_n = 1'b0;
        #1;
        chk("arst out_valid", 64'(out_valid), 64'd0);
        chk("arst out_bit", 64'(out_bit), 64'd0);
        chk("arst out_last", 64'(out_last), 64'd0);
        chk("arst busy", 64'(busy), 64'd0);
        chk("arst done", 64'(done), 64'd0);
        out_ready = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        chk("post-arst done", 64'(done), 64'd0);
        chk("post-arst busy", 64'(busy), 64'd0);
        chk("post-arst valid", 64'(out_valid), 64'd0);
        run_vec(20, tbl[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
